// File: rtl/cp0_exc_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions and
// exception codes for the MangoMIPS32 coprocessor-0 block.
package cp0_exc_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int STATUS_IM  = 8;
   localparam int STATUS_BEV = 22;
   localparam int CAUSE_EXC  = 2;
   localparam int CAUSE_IP   = 8;
   localparam int CAUSE_BD   = 31;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a Count prescaler and a sticky compare-match flag.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

   logic [PW-1:0] presc;
   logic          wrap;
   logic [31:0]   count_inc;

   assign wrap      = (presc == PRESC_LAST);
   assign count_inc = count + 32'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         count     <= '0;
         compare   <= '0;
         timer_int <= 1'b0;
      end else begin
         if (count_we) begin
            count <= wdata;
            presc <= '0;
         end else if (wrap) begin
            count <= count_inc;
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end
         if (compare_we)
            compare <= wdata;
         // Compare write acknowledges the timer, even against a coincident match.
         if (compare_we)
            timer_int <= 1'b0;
         else if (wrap && !count_we && (count_inc == compare))
            timer_int <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_exc.sv
// Coprocessor 0: Status/Cause/EPC/BadVAddr, interrupt request, exception entry
// and ERET, with the Count/Compare timer in cp0_timer.
module cp0_exc
   import cp0_exc_pkg::*;
#(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [4:0]            waddr,
   input  logic [31:0]           wdata,
   input  logic [4:0]            raddr,
   output logic [31:0]           rdata,
   input  logic [HW_INT_NUM-1:0] hw_int,
   input  logic                  exc_req,
   input  logic [4:0]            exc_code,
   input  logic [31:0]           exc_pc,
   input  logic                  exc_bd,
   input  logic                  exc_bva_wen,
   input  logic [31:0]           exc_bva,
   input  logic                  eret,
   output logic                  int_req,
   output logic [31:0]           exc_target,
   output logic                  timer_int
);

   logic [7:0]            status_im;
   logic                  status_exl;
   logic                  status_ie;
   logic                  cause_bd;
   logic [4:0]            cause_exc;
   logic [1:0]            cause_ip_sw;
   logic [HW_INT_NUM-1:0] cause_ip_hw;
   logic [31:0]           epc;
   logic [31:0]           badvaddr;
   logic [31:0]           count;
   logic [31:0]           compare;
   logic [7:0]            ip;
   logic [31:0]           status_val;
   logic [31:0]           cause_val;
   logic                  mtc0_ok;

   // MTC0 only lands when no exception or ERET commits in the same cycle.
   assign mtc0_ok = wen & ~exc_req & ~eret;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_ok && (waddr == CP0_COUNT)),
      .compare_we (mtc0_ok && (waddr == CP0_COMPARE)),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .timer_int  (timer_int)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         status_im   <= '0;
         status_exl  <= 1'b0;
         status_ie   <= 1'b0;
         cause_bd    <= 1'b0;
         cause_exc   <= '0;
         cause_ip_sw <= '0;
         cause_ip_hw <= '0;
         epc         <= '0;
         badvaddr    <= '0;
      end else begin
         cause_ip_hw <= hw_int;
         if (exc_req) begin
            cause_exc <= exc_code;
            if (exc_bva_wen)
               badvaddr <= exc_bva;
            // A nested exception keeps the outer handler's return point.
            if (!status_exl) begin
               epc        <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
               cause_bd   <= exc_bd;
               status_exl <= 1'b1;
            end
         end else if (eret) begin
            status_exl <= 1'b0;
         end else if (wen) begin
            case (waddr)
               CP0_STATUS: begin
                  status_im  <= wdata[STATUS_IM +: 8];
                  status_exl <= wdata[STATUS_EXL];
                  status_ie  <= wdata[STATUS_IE];
               end
               CP0_CAUSE: cause_ip_sw <= wdata[CAUSE_IP +: 2];
               CP0_EPC:   epc <= wdata;
               default:   ;
            endcase
         end
      end
   end

   always_comb begin
      ip               = '0;
      ip[1:0]          = cause_ip_sw;
      ip[2 +: HW_INT_NUM] = cause_ip_hw;
      ip[7]            = ip[7] | timer_int;
   end

   always_comb begin
      status_val                   = '0;
      status_val[STATUS_BEV]       = 1'b1;
      status_val[STATUS_IM +: 8]   = status_im;
      status_val[STATUS_EXL]       = status_exl;
      status_val[STATUS_IE]        = status_ie;
      cause_val                    = '0;
      cause_val[CAUSE_BD]          = cause_bd;
      cause_val[CAUSE_IP +: 8]     = ip;
      cause_val[CAUSE_EXC +: 5]    = cause_exc;
   end

   always_comb begin
      case (raddr)
         CP0_BADVADDR: rdata = badvaddr;
         CP0_COUNT:    rdata = count;
         CP0_COMPARE:  rdata = compare;
         CP0_STATUS:   rdata = status_val;
         CP0_CAUSE:    rdata = cause_val;
         CP0_EPC:      rdata = epc;
         default:      rdata = '0;
      endcase
   end

   assign int_req    = status_ie & ~status_exl & (|(ip & status_im));
   assign exc_target = exc_req ? EXC_VECTOR : epc;

endmodule
